sync_track: RTL and testbench

Receive-side timing tracker for the 5G harden frame-sync path. It consumes the `trigger`/`long_cp` strobe pair produced by the frame-sync generator or carried across a link. It acquires symbol/slot/frame alignment from the first `long_cp` rising edge, then rebuilds local sample/symbol/slot/frame counters and checks every incoming strobe against the expected pattern. It reports lock state and misalignment errors to CSR/IRQ logic.

---
 rtl/sync_track.sv | 196 +++++++++++++++++++
 tb/tb_sync_track.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_track.sv
// Receive-side frame-timing tracker: acquires slot alignment from a long_cp edge,
// then rebuilds sample/symbol/slot/frame counters and polices every incoming strobe.
module sync_track #(
  parameter int FFT_SIZE   = 2048,
  parameter int CP_LEN1    = 160,
  parameter int CP_LEN2    = 144,
  parameter int SYM_LEN    = 14,
  parameter int SLOT_LEN   = 20,
  parameter int FRAM_LEN   = 1024,
  parameter int LOCK_SLOTS = 2,
  parameter int MISS_MAX   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [13:0] mode,
  input  logic        trigger,
  input  logic        long_cp,
  input  logic        clr_err,
  output logic        locked,
  output logic [15:0] sample_cnt,
  output logic [3:0]  symbol_cnt,
  output logic [7:0]  slot_cnt,
  output logic [9:0]  frame_cnt,
  output logic        sym_start,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic        lock_lost
);

  typedef enum logic [1:0] {IDLE, HUNT, VERIFY, LOCK} state_t;

  localparam logic [15:0] SLEN0_LAST = 16'(FFT_SIZE + CP_LEN1 - 1);
  localparam logic [15:0] SLEN_LAST  = 16'(FFT_SIZE + CP_LEN2 - 1);
  localparam logic [15:0] HALF_FFT   = 16'(FFT_SIZE / 2);
  localparam logic [3:0]  SYM_LAST   = 4'(SYM_LEN - 1);
  localparam logic [7:0]  SLOT_LAST  = 8'(SLOT_LEN - 1);
  localparam logic [9:0]  FRAME_LAST = 10'(FRAM_LEN - 1);
  localparam logic [7:0]  GOOD_LIM   = 8'(LOCK_SLOTS);
  localparam logic [7:0]  MISS_LIM   = 8'(MISS_MAX);

  state_t      state, state_next;
  logic        long_cp_d;
  logic [7:0]  good_cnt, good_next;
  logic [7:0]  miss_cnt, miss_next;
  logic        slot_err, slot_err_next;

  logic [15:0] sample_next, sample_adv;
  logic [3:0]  symbol_next, symbol_adv;
  logic [7:0]  slot_next, slot_adv;
  logic [9:0]  frame_next, frame_adv;

  logic [15:0] mode_ext;
  logic        sample_wrap, symbol_wrap, slot_wrap;
  logic        exp_trig, exp_lcp, mismatch, lcp_rise;
  logic        err_hit, lost_hit;

  assign mode_ext    = {2'b00, mode};
  assign sample_wrap = (sample_cnt == ((symbol_cnt == 4'd0) ? SLEN0_LAST : SLEN_LAST));
  // symbol_wrap is also the slot-end cycle
  assign symbol_wrap = sample_wrap && (symbol_cnt == SYM_LAST);
  assign slot_wrap   = symbol_wrap && (slot_cnt == SLOT_LAST);

  assign exp_trig = mode_ext[symbol_cnt] && (sample_cnt < HALF_FFT);
  assign exp_lcp  = exp_trig && (symbol_cnt == 4'd0);
  assign mismatch = (trigger != exp_trig) || (long_cp != exp_lcp);
  assign lcp_rise = long_cp && !long_cp_d;

  assign sample_adv = sample_wrap ? 16'd0 : sample_cnt + 16'd1;
  assign symbol_adv = !sample_wrap ? symbol_cnt : (symbol_wrap ? 4'd0 : symbol_cnt + 4'd1);
  assign slot_adv   = !symbol_wrap ? slot_cnt : (slot_wrap ? 8'd0 : slot_cnt + 8'd1);
  assign frame_adv  = !slot_wrap ? frame_cnt :
                      ((frame_cnt == FRAME_LAST) ? 10'd0 : frame_cnt + 10'd1);

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    sample_next   = sample_cnt;
    symbol_next   = symbol_cnt;
    slot_next     = slot_cnt;
    frame_next    = frame_cnt;
    good_next     = good_cnt;
    miss_next     = miss_cnt;
    slot_err_next = slot_err;
    err_hit       = 1'b0;
    lost_hit      = 1'b0;

    unique case (state)
      IDLE: state_next = HUNT;
      HUNT: begin
        if (lcp_rise) begin
          // The edge cycle is sample 0, so the counters land on sample 1.
          sample_next = 16'd1;
          symbol_next = 4'd0;
          slot_next   = 8'd0;
          frame_next  = 10'd0;
          good_next   = 8'd0;
          state_next  = VERIFY;
        end else begin
          {sample_next, symbol_next, slot_next, frame_next} =
            {sample_adv, symbol_adv, slot_adv, frame_adv};
        end
      end
      VERIFY: begin
        {sample_next, symbol_next, slot_next, frame_next} =
          {sample_adv, symbol_adv, slot_adv, frame_adv};
        if (mismatch) begin
          state_next = HUNT;
        end else if (symbol_wrap) begin
          good_next = good_cnt + 8'd1;
          if (good_next == GOOD_LIM) begin
            state_next    = LOCK;
            miss_next     = 8'd0;
            slot_err_next = 1'b0;
          end
        end
      end
      LOCK: begin
        {sample_next, symbol_next, slot_next, frame_next} =
          {sample_adv, symbol_adv, slot_adv, frame_adv};
        err_hit = mismatch;
        if (symbol_wrap) begin
          slot_err_next = 1'b0;
          if (slot_err || mismatch) begin
            miss_next = miss_cnt + 8'd1;
            if (miss_next == MISS_LIM) begin
              state_next = HUNT;
              lost_hit   = 1'b1;
              miss_next  = 8'd0;
            end
          end else begin
            miss_next = 8'd0;
          end
        end else begin
          slot_err_next = slot_err || mismatch;
        end
      end
      default: state_next = IDLE;
    endcase

    if (!enable) begin
      state_next    = IDLE;
      sample_next   = 16'd0;
      symbol_next   = 4'd0;
      slot_next     = 8'd0;
      frame_next    = 10'd0;
      good_next     = 8'd0;
      miss_next     = 8'd0;
      slot_err_next = 1'b0;
      err_hit       = 1'b0;
      lost_hit      = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      long_cp_d  <= 1'b0;
      good_cnt   <= 8'd0;
      miss_cnt   <= 8'd0;
      slot_err   <= 1'b0;
      sample_cnt <= 16'd0;
      symbol_cnt <= 4'd0;
      slot_cnt   <= 8'd0;
      frame_cnt  <= 10'd0;
      locked     <= 1'b0;
      sym_start  <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= 16'd0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= state_next;
      long_cp_d  <= long_cp;
      good_cnt   <= good_next;
      miss_cnt   <= miss_next;
      slot_err   <= slot_err_next;
      sample_cnt <= sample_next;
      symbol_cnt <= symbol_next;
      slot_cnt   <= slot_next;
      frame_cnt  <= frame_next;
      locked     <= enable && (state == LOCK);
      sym_start  <= ((state_next == VERIFY) || (state_next == LOCK)) && (sample_next == 16'd0);
      err_pulse  <= err_hit;
      lock_lost  <= lost_hit;
      if (clr_err) begin
        err_cnt <= 16'd0;
      end else if (err_hit && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sync_track.sv
// Randomized scoreboard bench for sync_track with shrunken numerology so that
// acquisition, lock loss and frame wrap all fit in a short run.
module tb_sync_track;

  localparam int FFT   = 16;
  localparam int CP1   = 6;
  localparam int CP2   = 4;
  localparam int SYML  = 14;
  localparam int SLOTL = 3;
  localparam int FRAML = 4;
  localparam int LOCKS = 2;
  localparam int MISSM = 3;

  localparam int SL0      = FFT + CP1;
  localparam int SL       = FFT + CP2;
  localparam int SLOT_CYC = SL0 + (SYML - 1) * SL;
  localparam int WRAP     = SLOT_CYC * SLOTL * FRAML;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [13:0] mode;
  logic        trigger;
  logic        long_cp;
  logic        clr_err;
  logic        locked;
  logic [15:0] sample_cnt;
  logic [3:0]  symbol_cnt;
  logic [7:0]  slot_cnt;
  logic [9:0]  frame_cnt;
  logic        sym_start;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic        lock_lost;

  sync_track #(
    .FFT_SIZE(FFT), .CP_LEN1(CP1), .CP_LEN2(CP2), .SYM_LEN(SYML),
    .SLOT_LEN(SLOTL), .FRAM_LEN(FRAML), .LOCK_SLOTS(LOCKS), .MISS_MAX(MISSM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .trigger(trigger), .long_cp(long_cp), .clr_err(clr_err),
    .locked(locked), .sample_cnt(sample_cnt), .symbol_cnt(symbol_cnt),
    .slot_cnt(slot_cnt), .frame_cnt(frame_cnt), .sym_start(sym_start),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int locked;
    int sample;
    int symbol;
    int slot;
    int frame;
    int sym_start;
    int err_pulse;
    int err_cnt;
    int lost;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  typedef enum {M_OFF, M_SEARCH, M_CHECK, M_TRACK} mstate_t;

  // Stimulus knobs and generator state.
  logic        en = 1'b0;
  logic [13:0] gen_mode = 14'h3FFF;
  logic [13:0] dut_mode = 14'h3FFF;
  logic        gen_on = 1'b0;
  int          gen_p = 0;
  int          inj_pm = 0;
  int          clr_pm = 0;
  logic        clr_once = 1'b0;
  logic        flip_req = 1'b0;
  logic        spur_req = 1'b0;

  // Reference tracker: position as one absolute integer since acquisition.
  mstate_t m_st = M_OFF;
  int      mq = 0;
  logic    m_prev = 1'b0;
  logic    m_bad = 1'b0;
  int      m_run = 0;
  int      m_errs = 0;

  function automatic void decode(input int p, output int s, output int y,
                                 output int sl, output int fr);
    int off;
    off = p % SLOT_CYC;
    if (off < SL0) begin
      y = 0;
      s = off;
    end else begin
      y = 1 + (off - SL0) / SL;
      s = (off - SL0) % SL;
    end
    sl = (p / SLOT_CYC) % SLOTL;
    fr = (p / (SLOT_CYC * SLOTL)) % FRAML;
  endfunction

  // {long_cp, trigger} a correctly aligned source shows at absolute position p.
  function automatic logic [1:0] strobes(input int p, input logic [13:0] m);
    int s, y, sl, fr;
    logic tr;
    decode(p, s, y, sl, fr);
    tr = m[y] && (s < FFT / 2);
    return {tr && (y == 0), tr};
  endfunction

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
    end
  endtask

  task automatic push_zero(input int due);
    exp_t e;
    e = '{due: due, locked: 0, sample: 0, symbol: 0, slot: 0, frame: 0,
          sym_start: 0, err_pulse: 0, err_cnt: 0, lost: 0};
    sbq.push_back(e);
  endtask

  // One input cycle: drive the source, advance the reference, queue the
  // outputs expected after the sampling edge, then wait for that edge.
  task automatic step();
    int s, y, sl, fr;
    logic t, l, clr, mm, rise, last, bsl, pulse, lost, was_track;
    logic [1:0] st;
    exp_t e;

    st = gen_on ? strobes(gen_p, gen_mode) : 2'b00;
    t  = st[0];
    l  = st[1];
    decode(mq, s, y, sl, fr);
    if (flip_req && m_st == M_TRACK && y == 3 && s == 12) begin
      t = 1'b1;
      flip_req = 1'b0;
    end
    if (spur_req && m_st == M_CHECK && y == 2 && s == 10) begin
      l = 1'b1;
      spur_req = 1'b0;
    end
    if (inj_pm != 0 && $urandom_range(999, 0) < inj_pm) t = ~t;
    clr = clr_once || (clr_pm != 0 && $urandom_range(999, 0) < clr_pm);
    clr_once = 1'b0;

    enable  = en;
    mode    = dut_mode;
    trigger = t;
    long_cp = l;
    clr_err = clr;

    st        = strobes(mq, dut_mode);
    mm        = (t != st[0]) || (l != st[1]);
    rise      = l && !m_prev;
    last      = (mq % SLOT_CYC) == SLOT_CYC - 1;
    was_track = (m_st == M_TRACK);
    pulse     = 1'b0;
    lost      = 1'b0;

    if (!en) begin
      m_st  = M_OFF;
      mq    = 0;
      m_bad = 1'b0;
      m_run = 0;
    end else begin
      case (m_st)
        M_OFF: m_st = M_SEARCH;
        M_SEARCH: begin
          if (rise) begin
            mq   = 1;
            m_st = M_CHECK;
          end else begin
            mq = (mq + 1) % WRAP;
          end
        end
        M_CHECK: begin
          if (mm) m_st = M_SEARCH;
          else if (mq == LOCKS * SLOT_CYC - 1) begin
            m_st  = M_TRACK;
            m_bad = 1'b0;
            m_run = 0;
          end
          mq = (mq + 1) % WRAP;
        end
        M_TRACK: begin
          pulse = mm;
          if (mm && m_errs < 65535) m_errs++;
          bsl = m_bad || mm;
          if (last) begin
            m_bad = 1'b0;
            if (bsl) begin
              m_run++;
              if (m_run == MISSM) begin
                m_st  = M_SEARCH;
                lost  = 1'b1;
                m_run = 0;
              end
            end else begin
              m_run = 0;
            end
          end else begin
            m_bad = bsl;
          end
          mq = (mq + 1) % WRAP;
        end
        default: m_st = M_OFF;
      endcase
    end
    if (clr) m_errs = 0;
    m_prev = l;

    decode(mq, s, y, sl, fr);
    e.due       = cyc + 1;
    e.locked    = int'(en && was_track);
    e.sample    = s;
    e.symbol    = y;
    e.slot      = sl;
    e.frame     = fr;
    e.sym_start = int'((m_st == M_CHECK || m_st == M_TRACK) && s == 0);
    e.err_pulse = int'(pulse);
    e.err_cnt   = m_errs;
    e.lost      = int'(lost);
    sbq.push_back(e);

    if (gen_on) gen_p = (gen_p + 1) % WRAP;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Monitor: compares every queued expectation once its edge has happened.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check("locked",     int'(locked),     e.locked);
      check("sample_cnt", int'(sample_cnt), e.sample);
      check("symbol_cnt", int'(symbol_cnt), e.symbol);
      check("slot_cnt",   int'(slot_cnt),   e.slot);
      check("frame_cnt",  int'(frame_cnt),  e.frame);
      check("sym_start",  int'(sym_start),  e.sym_start);
      check("err_pulse",  int'(err_pulse),  e.err_pulse);
      check("err_cnt",    int'(err_cnt),    e.err_cnt);
      check("lock_lost",  int'(lock_lost),  e.lost);
    end
  end

  initial begin
    int k;
    rst_n = 1'b0; enable = 1'b0; mode = 14'h0;
    trigger = 1'b0; long_cp = 1'b0; clr_err = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      push_zero(cyc);
    end
    rst_n = 1'b1;

    // Acquire on a randomly delayed source with a random mask (bit 0 set).
    gen_mode = 14'($urandom) | 14'h1;
    dut_mode = gen_mode;
    run(4);
    en = 1'b1;
    run($urandom_range(200, 3));
    gen_on = 1'b1;
    gen_p  = 0;
    run(3 * SLOT_CYC + 20);

    // Single forced trigger in symbol 3 outside the strobe window.
    flip_req = 1'b1;
    run(2 * SLOT_CYC);

    // Sparse random corruption and clears across a full frame-counter wrap.
    inj_pm = 1;
    clr_pm = 2;
    run(WRAP + SLOT_CYC);
    inj_pm = 0;
    clr_pm = 0;

    // Source restarted 7 samples late: lock loss then re-acquisition.
    gen_p = (gen_p + WRAP - 7) % WRAP;
    run(7 * SLOT_CYC);

    // Re-hunt, then a spurious long_cp while verifying.
    en = 1'b0;
    run(3);
    en = 1'b1;
    spur_req = 1'b1;
    run(5 * SLOT_CYC);

    // Mask change while locked, then software re-hunt with the right mask.
    k = $urandom_range(13, 1);
    dut_mode = gen_mode ^ (14'd1 << k);
    run(5 * SLOT_CYC);
    dut_mode = gen_mode;
    en = 1'b0;
    run(2);
    en = 1'b1;
    run(4 * SLOT_CYC);

    // Inject a few errors, drop enable mid-slot, then clear the count.
    flip_req = 1'b1;
    run(SLOT_CYC + $urandom_range(150, 30));
    en = 1'b0;
    run(5);
    clr_once = 1'b1;
    run(5);

    // Relock and hit reset mid-slot: all outputs must drop at once.
    en = 1'b1;
    run(4 * SLOT_CYC + $urandom_range(200, 20));
    void'(sbq.pop_back());
    rst_n = 1'b0;
    push_zero(cyc);
    @(posedge clk); #1;
    push_zero(cyc);
    @(posedge clk); #1;
    push_zero(cyc);
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
